// File: rtl/fifo_uart_tx_pkg.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx_pkg
//   Shared definitions for the FIFO-draining UART transmitter.
//   - tx_state_t   : transmitter FSM states
//   - TX_IDLE_LVL  : serial line level while idle / during stop bits
//   - TX_START_LVL : serial line level of the start bit
//   Build option: FIFO_UART_TX_PARITY_EN adds the PARITY state.
// ----------------------------------------------------------------------------
package fifo_uart_tx_pkg;

`ifdef FIFO_UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } tx_state_t;
`endif

    localparam logic TX_IDLE_LVL  = 1'b1;
    localparam logic TX_START_LVL = 1'b0;

endpackage

// File: rtl/fifo_uart_tx_baud.sv
// ----------------------------------------------------------------------------
// tx_baud_counter
//   Free-running bit-time counter for the UART transmitter. Counts
//   0..CLKS_PER_BIT-1 and wraps; tick is high in the wrap cycle.
//   Ports:
//     clk    in   rising-edge clock
//     reset  in   synchronous active-high reset
//     clear  in   holds the count at zero (used while no bit is on the line)
//     count  out  current position inside the bit time
//     tick   out  1 in the last cycle of each bit time
// ----------------------------------------------------------------------------
module tx_baud_counter #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    // Count through one bit time; clear parks the counter so the first
    // cycle of a start bit always begins at zero.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == LAST_CNT) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST_CNT) && !clear;

endmodule

// File: rtl/fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// fifo_uart_tx
//   Drain end of fifo_buffer: pops a byte whenever the FIFO is non-empty and
//   sends it as an asynchronous serial frame (start, DATA_W bits LSB first,
//   optional even parity, STOP_BITS stop bits).
//   Build option: define FIFO_UART_TX_PARITY_EN to insert an even-parity bit
//   between the data bits and the stop bits.
//   Ports:
//     clk         in   rising-edge clock
//     reset       in   synchronous active-high reset (aborts a frame)
//     fifo_empty  in   FIFO empty flag
//     fifo_data   in   FIFO registered read data (valid cycle after rd_en)
//     fifo_rd_en  out  one-cycle read pulse per byte
//     tx          out  serial line, idles high
//     busy        out  high from POP to the end of the frame
//     tx_done     out  one-cycle pulse in the final stop cycle
// ----------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    tx_state_t          state;
    logic [DATA_W-1:0]  shift_reg;
    logic [DATA_W-1:0]  next_shift;
    logic [BIT_W-1:0]   bit_cnt;
    logic               stop_cnt;
    logic               baud_clear;
    logic               baud_tick;
    logic [CNT_W-1:0]   baud_count;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               parity_bit;
`endif

    // The bit timer only runs while a bit is actually on the line, so every
    // start bit begins with a fresh count.
    assign baud_clear = (state == IDLE) || (state == POP) || (state == LOAD);
    assign next_shift = shift_reg >> 1;

    tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (baud_clear),
        .count (baud_count),
        .tick  (baud_tick)
    );

    // Frame sequencer. All outputs are registered here; each state sets the
    // line level for the next bit when the bit timer wraps. tx_done is set
    // one cycle early so that it lands in the final stop cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= TX_IDLE_LVL;
            fifo_rd_en <= 1'b0;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (state)
                IDLE: begin
                    tx   <= TX_IDLE_LVL;
                    busy <= 1'b0;
                    if (!fifo_empty) begin
                        state      <= POP;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                POP: begin
                    state <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_bit <= ^fifo_data;
`endif
                    bit_cnt   <= '0;
                    stop_cnt  <= 1'b0;
                    tx        <= TX_START_LVL;
                    state     <= START;
                end
                START: begin
                    if (baud_tick) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
                            tx    <= parity_bit;
                            state <= PARITY;
`else
                            tx    <= TX_IDLE_LVL;
                            state <= STOP;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= next_shift;
                            tx        <= next_shift[0];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tick) begin
                        tx    <= TX_IDLE_LVL;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if ((stop_cnt == LAST_STOP) && (baud_count == DONE_CNT)) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            if (!fifo_empty) begin
                                state      <= POP;
                                fifo_rd_en <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ----------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Bench for fifo_uart_tx with CLKS_PER_BIT=4, DATA_W=8, STOP_BITS=1 and a
//   small fifo_buffer model. Stimulus pushes bytes (with hand-computed parity)
//   into the FIFO model and the expected queue; a monitor decodes frames off
//   tx and compares them against that queue.
//   Build option: FIFO_UART_TX_PARITY_EN enables the parity frame tests.
// ----------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int DATA_W       = 8;
    localparam int CLKS_PER_BIT = 4;
    localparam int STOP_BITS    = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;
    localparam int FRAME_CYC  = FRAME_BITS * CLKS_PER_BIT;

    logic              clk   = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] fifo_data = '0;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              tx;
    logic              busy;
    logic              tx_done;

    logic [DATA_W-1:0] fifo_mem [0:63];
    int push_count  = 0;
    int pop_count   = 0;
    int rd_pulses   = 0;
    int rd_err      = 0;
    int done_pulses = 0;

    logic [DATA_W:0] exp_q [$];
    int              gaps_q [$];

    int checks   = 0;
    int failures = 0;

    assign fifo_empty = (push_count == pop_count);

    always #5 clk = ~clk;

    fifo_uart_tx #(
        .DATA_W       (DATA_W),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy),
        .tx_done    (tx_done)
    );

    // fifo_buffer read side: registered read data, plus pulse bookkeeping.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_pulses <= rd_pulses + 1;
            if (push_count == pop_count) begin
                rd_err <= rd_err + 1;
            end else begin
                fifo_data <= fifo_mem[pop_count % 64];
                pop_count <= pop_count + 1;
            end
        end
        if (tx_done) begin
            done_pulses <= done_pulses + 1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Push one byte into the FIFO model and its expected frame into the queue.
    task automatic applyStimulus(input logic [DATA_W-1:0] data, input logic par);
        fifo_mem[push_count % 64] = data;
        exp_q.push_back({par, data});
        push_count++;
    endtask

    task automatic waitDrained(input int budget);
        int  n;
        logic drained;
        n = 0;
        drained = 1'b0;
        while (!drained && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            drained = (exp_q.size() == 0) && !busy && fifo_empty;
        end
        checkOutput("drain_in_time", {31'b0, drained}, 1);
    endtask

    // Frame monitor: samples on the falling edge, decodes one frame per
    // start bit and checks it against the expected queue.
    initial begin : monitor
        logic [FRAME_CYC-1:0] tx_s;
        logic [FRAME_CYC-1:0] done_s;
        logic [FRAME_CYC-1:0] busy_s;
        logic [DATA_W-1:0]    rx;
        logic [DATA_W:0]      exp_e;
        logic                 aborted;
        logic                 shape_ok;
        logic                 done_ok;
        int                   cyc;
        int                   start_cyc;
        int                   last_done_cyc;
        cyc = 0;
        last_done_cyc = -100;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset && tx == 1'b0) begin
                start_cyc = cyc;
                tx_s = '0;
                done_s = '0;
                busy_s = '0;
                tx_s[0] = tx;
                done_s[0] = tx_done;
                busy_s[0] = busy;
                aborted = 1'b0;
                for (int s = 1; s < FRAME_CYC; s++) begin
                    @(negedge clk);
                    cyc++;
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    tx_s[s] = tx;
                    done_s[s] = tx_done;
                    busy_s[s] = busy;
                end
                if (aborted) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    $display("[TB] frame aborted by reset at cycle %0d", cyc);
                end else begin
                    shape_ok = 1'b1;
                    done_ok = 1'b1;
                    rx = '0;
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        for (int k = 0; k < CLKS_PER_BIT; k++) begin
                            if (tx_s[b*CLKS_PER_BIT+k] !== tx_s[b*CLKS_PER_BIT]) shape_ok = 1'b0;
                            if (busy_s[b*CLKS_PER_BIT+k] !== 1'b1) shape_ok = 1'b0;
                            if (done_s[b*CLKS_PER_BIT+k] !== ((b*CLKS_PER_BIT+k) == FRAME_CYC-1))
                                done_ok = 1'b0;
                        end
                    end
                    for (int b = 1 + DATA_W + PAR_BITS; b < FRAME_BITS; b++) begin
                        if (tx_s[b*CLKS_PER_BIT] !== 1'b1) shape_ok = 1'b0;
                    end
                    for (int i = 0; i < DATA_W; i++) begin
                        rx[i] = tx_s[(1+i)*CLKS_PER_BIT];
                    end
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_frame", {24'b0, rx}, 32'hFFFF_FFFF);
                    end else begin
                        exp_e = exp_q.pop_front();
                        checkOutput("rx_byte", {24'b0, rx}, {24'b0, exp_e[DATA_W-1:0]});
`ifdef FIFO_UART_TX_PARITY_EN
                        checkOutput("parity_bit", {31'b0, tx_s[(1+DATA_W)*CLKS_PER_BIT]},
                                    {31'b0, exp_e[DATA_W]});
`endif
                    end
                    checkOutput("frame_shape", {31'b0, shape_ok}, 1);
                    checkOutput("tx_done_position", {31'b0, done_ok}, 1);
                    gaps_q.push_back(start_cyc - last_done_cyc - 1);
                    last_done_cyc = cyc;
                end
            end
        end
    end

    // Directed test sequence.
    initial begin : stimulus
        int d_before;
        int r_before;
        int n;
        logic [DATA_W-1:0] t3_bytes [8];
        logic              t3_par   [8];
        t3_bytes = '{8'h01, 8'h09, 8'h07, 8'h03, 8'h04, 8'h06, 8'h08, 8'h0A};
        t3_par   = '{1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0};

        // 1: reset, then an empty FIFO keeps the line idle.
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx", {31'b0, tx}, 1);
        checkOutput("reset_busy", {31'b0, busy}, 0);
        checkOutput("reset_rd_en", {31'b0, fifo_rd_en}, 0);
        checkOutput("reset_tx_done", {31'b0, tx_done}, 0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            checkOutput("idle_lines", {28'b0, tx, busy, fifo_rd_en, tx_done}, 32'h8);
        end

        // 2: single byte, latency and one pulse each.
        d_before = done_pulses;
        r_before = rd_pulses;
        applyStimulus(8'h01, 1'b1);
        @(posedge clk); #1;
        checkOutput("t2_rd_en_cycle1", {31'b0, fifo_rd_en}, 1);
        checkOutput("t2_busy_cycle1", {31'b0, busy}, 1);
        @(posedge clk); #1;
        checkOutput("t2_rd_en_cycle2", {31'b0, fifo_rd_en}, 0);
        checkOutput("t2_tx_cycle2", {31'b0, tx}, 1);
        @(posedge clk); #1;
        checkOutput("t2_tx_cycle3", {31'b0, tx}, 0);
        waitDrained(200);
        checkOutput("t2_rd_pulses", rd_pulses - r_before, 1);
        checkOutput("t2_done_pulses", done_pulses - d_before, 1);
        checkOutput("t2_busy_after", {31'b0, busy}, 0);
        checkOutput("t2_tx_after", {31'b0, tx}, 1);

        // 3: eight preloaded bytes, back to back.
        repeat (5) @(posedge clk);
        #1;
        gaps_q.delete();
        d_before = done_pulses;
        r_before = rd_pulses;
        for (int i = 0; i < 8; i++) applyStimulus(t3_bytes[i], t3_par[i]);
        waitDrained(600);
        checkOutput("t3_rd_pulses", rd_pulses - r_before, 8);
        checkOutput("t3_done_pulses", done_pulses - d_before, 8);
        checkOutput("t3_frames", gaps_q.size(), 8);
        for (int i = 1; i < 8; i++) begin
            checkOutput($sformatf("t3_gap%0d", i),
                        (i < gaps_q.size()) ? gaps_q[i] : -1, 2);
        end
        checkOutput("t3_empty_after", {31'b0, fifo_empty}, 1);

        // 4: reset in data bit 3 of 8'hA5; 8'h3C must follow intact.
        repeat (5) @(posedge clk);
        #1;
        d_before = done_pulses;
        r_before = rd_pulses;
        applyStimulus(8'hA5, 1'b0);
        applyStimulus(8'h3C, 1'b0);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t4_start_seen", {31'b0, tx}, 0);
        repeat (4 + 3*CLKS_PER_BIT + 1) @(posedge clk);
        #1;
        checkOutput("t4_bit3_level", {31'b0, tx}, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("t4_abort_tx", {31'b0, tx}, 1);
        checkOutput("t4_abort_tx_done", {31'b0, tx_done}, 0);
        checkOutput("t4_abort_busy", {31'b0, busy}, 0);
        checkOutput("t4_abort_rd_en", {31'b0, fifo_rd_en}, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("t4_no_done_on_abort", done_pulses - d_before, 0);
        waitDrained(200);
        checkOutput("t4_done_after", done_pulses - d_before, 1);
        checkOutput("t4_rd_pulses", rd_pulses - r_before, 2);

`ifdef FIFO_UART_TX_PARITY_EN
        // 5: parity frames.
        repeat (5) @(posedge clk);
        #1;
        d_before = done_pulses;
        applyStimulus(8'h07, 1'b1);
        applyStimulus(8'h03, 1'b0);
        waitDrained(200);
        checkOutput("t5_done_pulses", done_pulses - d_before, 2);
`endif

        // 6: push exactly in the last stop cycle.
        repeat (5) @(posedge clk);
        #1;
        gaps_q.delete();
        applyStimulus(8'h5A, 1'b0);
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("t6_done_seen", {31'b0, tx_done}, 1);
        applyStimulus(8'hC3, 1'b0);
        @(posedge clk); #1;
        checkOutput("t6_pop_next", {31'b0, fifo_rd_en}, 1);
        checkOutput("t6_busy_held", {31'b0, busy}, 1);
        waitDrained(200);
        checkOutput("t6_gap", (gaps_q.size() > 1) ? gaps_q[1] : -1, 2);

        checkOutput("rd_en_while_empty", rd_err, 0);
        checkOutput("scoreboard_left", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit.
    initial begin : watchdog
        #200000;
        failures++;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] time limit reached");
    end

endmodule
